instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit that sits between instruction memory and the controller. It issues word reads over a req/ack handshake and buffers up to two fetched words with their addresses. It presents the oldest word to the controller as `I` with `W_IR_valid`. It advances sequentially on its own and flushes and refetches when the controller redirects the PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] are ignored and treated as 0.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_req` out 1: read request, registered; held high until acknowledged.
- `mem_addr` out 32: word address of the request, registered; stable while `mem_req` is high.
- `mem_ack` in 1: read completion; sampled only on edges where `mem_req` is high.
- `mem_rdata` in 32: read data; valid in the cycle `mem_ack` is high.
- `I` out 32: instruction at the buffer head; 32'h0 when the buffer is empty.
- `I_pc` out 32: address of the word on `I`; 32'h0 when the buffer is empty.
- `W_IR_valid` out 1: buffer non-empty.
- `write_ir` in 1: controller consumes the head entry; ignored when `W_IR_valid` is low.
- `write_pc` in 1: controller PC write strobe.
- `pc_s` in 2: PC source select. 00 = sequential (no redirect), 01 = `target_a`, 10 = `target_b`, 11 = treated as 00.
- `target_a` in 32: redirect target (ALU result).
- `target_b` in 32: redirect target (register operand).

## Operation
- State: `fetch_pc` (32 bits, word aligned), a 2-entry FIFO of {pc, instr} with `count` in 0..2, and an FSM with states IDLE, BUSY and DISCARD.
- Redirect condition: `write_pc` high and `pc_s` is 01 or 10. The target is `target_a` or `target_b` with bits [1:0] forced to 00.
- IDLE:
  - No redirect and `count` < 2: set `mem_req`=1 and `mem_addr`=`fetch_pc`, then go to BUSY.
  - `count` == 2: wait in IDLE.
- BUSY, `mem_ack` high:
  - Push {`mem_addr`, `mem_rdata`}.
  - Set `fetch_pc` = `mem_addr` + 4 (wraps modulo 2^32).
  - Set `mem_req`=0 and go to IDLE.
  - Space is guaranteed, because a request is only issued when `count` < 2 and `count` only decreases while BUSY.
- DISCARD: hold `mem_req` until `mem_ack`. Drop the returned data, set `mem_req`=0, and go to IDLE. `fetch_pc` already holds the redirect target.
- Redirect, in any state:
  - FIFO is flushed (`count`=0) and `fetch_pc` is loaded with the target.
  - A `write_ir` in the same cycle is ignored.
  - If BUSY with `mem_ack` low, go to DISCARD.
  - If BUSY with `mem_ack` high, drop the data and go to IDLE.
  - If IDLE, no request is issued this cycle; go to IDLE.
  - If DISCARD, stay in DISCARD.
  - A later redirect overrides an earlier target.
- Pop: `write_ir` && `W_IR_valid` && no redirect removes the head entry. A push and a pop in the same cycle keep `count` unchanged.
- `write_pc` with `pc_s` 00 or 11 has no effect.
- At most one request is outstanding at any time.

## Timing
- Reset (`rst`=0), asynchronous:
  - State = IDLE, `fetch_pc`=`RESET_PC`, `count`=0.
  - `mem_req`=0, `mem_addr`=`RESET_PC`.
  - `W_IR_valid`=0, `I`=0, `I_pc`=0.
  - Reset mid-request abandons the request; memory must tolerate `mem_req` dropping.
- First edge after reset release: `mem_req` goes high.
- Zero-wait memory (`mem_ack` combinationally high with `mem_req`):
  - `W_IR_valid` goes high after the 2nd edge.
  - Throughput is one word per 2 cycles.
- A memory with N wait cycles adds N cycles per fetch.
- Flush is seen one cycle after the redirect edge: `W_IR_valid`=0.
- The first word from the target is visible no earlier than 3 edges after a redirect taken in IDLE.
- `I` and `I_pc` change only on edges. The head entry is stable until it is popped or flushed.

## Test plan
- Reset and stream, with `RESET_PC`=0x100 and zero-wait memory returning data = address XOR 0xA5A5_0000. Required: `W_IR_valid` high after edge 2 with `I_pc`=0x100, then 0x104, 0x108 in order, with `write_ir` held high.
- Backpressure, with `write_ir`=0. Required: exactly two requests (0x100, 0x104), then `mem_req` stays low. One `write_ir` pulse lets the request for 0x108 issue on the next edge.
- Redirect while BUSY, with the ack delayed 3 cycles and `write_pc`=1, `pc_s`=01, `target_a`=0x2003. Required: FSM enters DISCARD, the late data never appears on `I`, and the next request address is 0x2000.
- Redirect coincident with `mem_ack` and `write_ir`, using `pc_s`=10 and `target_b`=0x40. Required: data dropped, no pop, `count`=0 next cycle, next `mem_addr`=0x40.
- Wrap-around at 0xFFFF_FFFC. Required: the next fetch is 0x0000_0000. Also, `pc_s`=00 or 11 with `write_pc` causes no flush.
- Async reset asserted mid-BUSY. Required: `mem_req` and `W_IR_valid` drop immediately without a clock, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding word reads over req/ack,
// 2-entry {pc, instr} buffer, flush and refetch on controller PC redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] I,
  output logic [31:0] I_pc,
  output logic        W_IR_valid,
  input  logic        write_ir,
  input  logic        write_pc,
  input  logic [1:0]  pc_s,
  input  logic [31:0] target_a,
  input  logic [31:0] target_b
);

  localparam logic [1:0]  S_IDLE     = 2'd0;
  localparam logic [1:0]  S_BUSY     = 2'd1;
  localparam logic [1:0]  S_DISCARD  = 2'd2;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RST_PC_AL  = RESET_PC & ALIGN_MASK;

  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [1:0]  r_count;
  logic [31:0] r_pc0, r_ins0, r_pc1, r_ins1;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_ack;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_wr_idx;

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  // Empty slots are kept at zero so the head registers drive I/I_pc directly.
  assign I          = r_ins0;
  assign I_pc       = r_pc0;
  assign W_IR_valid = (r_count != 2'd0);

  assign w_redirect = write_pc & ((pc_s == 2'b01) | (pc_s == 2'b10));
  assign w_ack      = r_mem_req & mem_ack;
  assign w_push     = (r_state == S_BUSY) & w_ack & ~w_redirect;
  assign w_pop      = write_ir & W_IR_valid & ~w_redirect;
  assign w_wr_idx   = r_count - {1'b0, w_pop};

  // Redirect target selection, word aligned.
  always_comb begin
    w_target = target_a & ALIGN_MASK;
    if (pc_s == 2'b10) begin
      w_target = target_b & ALIGN_MASK;
    end else begin
      w_target = target_a & ALIGN_MASK;
    end
  end

  // Fetch FSM: request issue, completion, discard of redirected requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RST_PC_AL;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RST_PC_AL;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_redirect) begin
            r_fetch_pc <= w_target;
          end else if (r_count != 2'd2) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_redirect) begin
            r_fetch_pc <= w_target;
            if (w_ack) begin
              r_mem_req <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_state   <= S_DISCARD;
            end
          end else if (w_ack) begin
            r_fetch_pc <= r_mem_addr + 32'd4;
            r_mem_req  <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_DISCARD: begin
          if (w_redirect) begin
            r_fetch_pc <= w_target;
          end
          // The outstanding read still has to complete before a new one issues.
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Two-entry buffer: shift on pop, write behind the survivors on push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 2'd0;
      r_pc0   <= 32'd0;
      r_ins0  <= 32'd0;
      r_pc1   <= 32'd0;
      r_ins1  <= 32'd0;
    end else if (w_redirect) begin
      r_count <= 2'd0;
      r_pc0   <= 32'd0;
      r_ins0  <= 32'd0;
      r_pc1   <= 32'd0;
      r_ins1  <= 32'd0;
    end else begin
      if (w_pop) begin
        r_pc0  <= r_pc1;
        r_ins0 <= r_ins1;
        r_pc1  <= 32'd0;
        r_ins1 <= 32'd0;
      end
      if (w_push) begin
        if (w_wr_idx == 2'd0) begin
          r_pc0  <= r_mem_addr;
          r_ins0 <= mem_rdata;
        end else begin
          r_pc1  <= r_mem_addr;
          r_ins1 <= mem_rdata;
        end
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: transaction-level fetch model with a
// wait-state memory, directed scenarios and a randomized controller phase.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] I;
  logic [31:0] I_pc;
  logic        W_IR_valid;
  logic        write_ir;
  logic        write_pc;
  logic [1:0]  pc_s;
  logic [31:0] target_a;
  logic [31:0] target_b;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .I(I), .I_pc(I_pc), .W_IR_valid(W_IR_valid),
    .write_ir(write_ir), .write_pc(write_pc), .pc_s(pc_s),
    .target_a(target_a), .target_b(target_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        m_q[$];
  logic        m_pending;
  logic        m_drop;
  logic [31:0] m_addr;
  logic [31:0] m_fpc;

  int          n_checks;
  int          n_err;
  int          wait_left;
  int          wait_fix;
  bit          wait_rand;
  logic [31:0] seen[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour at one rising edge, from the values driven before it.
  task automatic model_step();
    logic        redir;
    logic        done;
    logic [31:0] tgt;
    int          n;
    if (!rst) begin
      m_q.delete();
      m_pending = 1'b0;
      m_drop    = 1'b0;
      m_addr    = RST_PC;
      m_fpc     = RST_PC;
      return;
    end
    redir = write_pc && (pc_s == 2'b01 || pc_s == 2'b10);
    tgt   = ((pc_s == 2'b10) ? target_b : target_a) & 32'hFFFF_FFFC;
    done  = m_pending && mem_ack;
    n     = m_q.size();
    if (redir) begin
      m_q.delete();
      m_fpc = tgt;
      if (done) begin
        m_pending = 1'b0;
        m_drop    = 1'b0;
      end else if (m_pending) begin
        m_drop = 1'b1;
      end
    end else begin
      if (write_ir && n > 0) void'(m_q.pop_front());
      if (done) begin
        if (!m_drop) begin
          m_q.push_back('{m_addr, m_addr ^ KEY});
          m_fpc = m_addr + 32'd4;
        end
        m_pending = 1'b0;
        m_drop    = 1'b0;
      end else if (!m_pending && n < 2) begin
        m_pending = 1'b1;
        m_addr    = m_fpc;
      end
    end
  endtask

  task automatic check_outputs();
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_pending});
    chk("mem_addr", mem_addr, m_addr);
    chk("W_IR_valid", {31'd0, W_IR_valid}, {31'd0, (m_q.size() > 0)});
    chk("I", I, (m_q.size() > 0) ? m_q[0].ins : 32'd0);
    chk("I_pc", I_pc, (m_q.size() > 0) ? m_q[0].pc : 32'd0);
  endtask

  // Memory: ack after wait_left cycles of a held request, data = addr ^ KEY.
  task automatic mem_drive();
    if (!mem_req) begin
      mem_ack   = 1'b0;
      wait_left = wait_rand ? int'($urandom_range(0, 3)) : wait_fix;
    end else begin
      mem_ack = (wait_left == 0);
      if (wait_left > 0) wait_left--;
    end
    mem_rdata = mem_addr ^ KEY;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    @(negedge clk);
    mem_drive();
  endtask

  task automatic clear_ctl();
    write_ir = 1'b0;
    write_pc = 1'b0;
    pc_s     = 2'b00;
    target_a = 32'd0;
    target_b = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_ctl();
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nreq;
    bit  prev_req;
    bit  found;
    bit  bad;
    logic [31:0] raddr[$];
    n_checks  = 0;
    n_err     = 0;
    wait_fix  = 0;
    wait_rand = 1'b0;
    wait_left = 0;
    rst       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    clear_ctl();
    @(negedge clk);

    // Reset and stream with zero-wait memory.
    do_reset();
    write_ir = 1'b1;
    tick();
    chk("t1_req", {31'd0, mem_req}, 32'd1);
    chk("t1_addr", mem_addr, 32'h0000_0100);
    tick();
    chk("t1_valid", {31'd0, W_IR_valid}, 32'd1);
    chk("t1_pc0", I_pc, 32'h0000_0100);
    chk("t1_i0", I, 32'hA5A5_0100);
    seen.delete();
    for (int k = 0; k < 6; k++) begin
      tick();
      if (W_IR_valid) seen.push_back(I_pc);
    end
    chk("t1_nseen", seen.size(), 32'd3);
    if (seen.size() >= 2) begin
      chk("t1_pc1", seen[0], 32'h0000_0104);
      chk("t1_pc2", seen[1], 32'h0000_0108);
    end

    // Backpressure: two fetches then stall; pc_s 00/11 must not flush.
    do_reset();
    nreq = 0;
    prev_req = 1'b0;
    raddr.delete();
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mem_req && !prev_req) begin
        nreq++;
        raddr.push_back(mem_addr);
      end
      prev_req = mem_req;
    end
    chk("t2_nreq", nreq, 32'd2);
    if (raddr.size() == 2) begin
      chk("t2_addr0", raddr[0], 32'h0000_0100);
      chk("t2_addr1", raddr[1], 32'h0000_0104);
    end
    chk("t2_stall", {31'd0, mem_req}, 32'd0);
    write_pc = 1'b1;
    pc_s     = 2'b00;
    target_a = 32'h0000_3000;
    target_b = 32'h0000_4000;
    tick();
    chk("t2_nop00", {31'd0, W_IR_valid}, 32'd1);
    pc_s = 2'b11;
    tick();
    chk("t2_nop11", I_pc, 32'h0000_0100);
    clear_ctl();
    write_ir = 1'b1;
    tick();
    write_ir = 1'b0;
    chk("t2_head", I_pc, 32'h0000_0104);
    tick();
    chk("t2_req108", {31'd0, mem_req}, 32'd1);
    chk("t2_addr108", mem_addr, 32'h0000_0108);

    // Redirect while BUSY with a 3-cycle ack delay.
    wait_fix = 3;
    do_reset();
    tick();
    write_pc = 1'b1;
    pc_s     = 2'b01;
    target_a = 32'h0000_2003;
    tick();
    clear_ctl();
    chk("t3_held", {31'd0, mem_req}, 32'd1);
    found = 1'b0;
    bad   = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (W_IR_valid && I_pc == 32'h0000_0100) bad = 1'b1;
      if (mem_req && mem_addr != 32'h0000_0100) found = 1'b1;
    end
    chk("t3_found", {31'd0, found}, 32'd1);
    chk("t3_addr", mem_addr, 32'h0000_2000);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (W_IR_valid && I_pc == 32'h0000_0100) bad = 1'b1;
      found = W_IR_valid;
    end
    chk("t3_nolate", {31'd0, bad}, 32'd0);
    chk("t3_pc", I_pc, 32'h0000_2000);
    chk("t3_i", I, 32'hA5A5_2000);

    // Redirect coincident with ack and write_ir.
    wait_fix = 0;
    do_reset();
    tick();
    tick();
    tick();
    chk("t4_busy", mem_addr, 32'h0000_0104);
    write_ir = 1'b1;
    write_pc = 1'b1;
    pc_s     = 2'b10;
    target_a = 32'h0000_0999;
    target_b = 32'h0000_0040;
    tick();
    clear_ctl();
    chk("t4_flush", {31'd0, W_IR_valid}, 32'd0);
    chk("t4_noreq", {31'd0, mem_req}, 32'd0);
    tick();
    chk("t4_addr", mem_addr, 32'h0000_0040);

    // Wrap-around of the sequential address.
    do_reset();
    write_ir = 1'b1;
    write_pc = 1'b1;
    pc_s     = 2'b01;
    target_a = 32'hFFFF_FFFE;
    tick();
    write_pc = 1'b0;
    chk("t5_idle", {31'd0, mem_req}, 32'd0);
    tick();
    chk("t5_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t5_pc", I_pc, 32'hFFFF_FFFC);
    tick();
    chk("t5_wrap", mem_addr, 32'h0000_0000);
    clear_ctl();

    // Asynchronous reset in the middle of a request.
    wait_fix = 3;
    do_reset();
    for (int k = 0; k < 6; k++) tick();
    chk("t6_pre_valid", {31'd0, W_IR_valid}, 32'd1);
    chk("t6_pre_req", {31'd0, mem_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t6_valid_drop", {31'd0, W_IR_valid}, 32'd0);
    chk("t6_i_zero", I, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_restart", mem_addr, 32'h0000_0100);

    // Randomized controller traffic against the model.
    wait_rand = 1'b1;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      write_ir = ($urandom_range(0, 3) != 0);
      write_pc = ($urandom_range(0, 15) < 3);
      pc_s     = 2'($urandom_range(0, 3));
      target_a = $urandom;
      target_b = $urandom;
      tick();
    end
    clear_ctl();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
